closed_list_ctrl: RTL and testbench

Owns the A* closed-list storage: DEPTH entries of (x,y) coordinate pairs in a register array. It arbitrates between two requesters, the expand unit (lookup: "is this node closed?") and the commit unit (insert: "close this node"). It sequences one linear-scan comparison per cycle, appends on insert, and returns a single-cycle response pulse. It sits between the A* main FSM and the closed-list memory and replaces ad-hoc scan loops in the top-level FSM.

---
 rtl/closed_list_ctrl_if.sv | 29 ++
 rtl/closed_list_ctrl.sv | 182 ++++++++++++++++++
 tb/tb_closed_list_ctrl.sv | 271 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/closed_list_ctrl_if.sv
// rtl/closed_list_ctrl_if.sv - lookup/insert request and response bundle for the closed-list controller
interface closed_list_ctrl_if #(
    parameter int COORD_W = 8,
    parameter int IDX_W   = 9
);
    logic               lk_valid;
    logic               lk_ready;
    logic [COORD_W-1:0] lk_x;
    logic [COORD_W-1:0] lk_y;
    logic               ins_valid;
    logic               ins_ready;
    logic [COORD_W-1:0] ins_x;
    logic [COORD_W-1:0] ins_y;
    logic               rsp_valid;
    logic               rsp_op;
    logic               rsp_found;
    logic [IDX_W-1:0]   rsp_index;
    logic               rsp_err;

    modport master (
        output lk_valid, lk_x, lk_y, ins_valid, ins_x, ins_y,
        input  lk_ready, ins_ready, rsp_valid, rsp_op, rsp_found, rsp_index, rsp_err
    );

    modport slave (
        input  lk_valid, lk_x, lk_y, ins_valid, ins_x, ins_y,
        output lk_ready, ins_ready, rsp_valid, rsp_op, rsp_found, rsp_index, rsp_err
    );
endinterface

// File: rtl/closed_list_ctrl.sv
// rtl/closed_list_ctrl.sv - A* closed-list store with lookup/insert arbitration and linear scan
// Optional CLOSED_DEDUP_EN: inserts scan first and report an existing entry instead of storing it.
module closed_list_ctrl #(
    parameter int DEPTH   = 400,
    parameter int COORD_W = 8,
    parameter int IDX_W   = 9
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             clear,
    closed_list_ctrl_if.slave bus,
    output logic [IDX_W-1:0] count,
    output logic             full,
    output logic             busy
);

`ifdef CLOSED_DEDUP_EN
    localparam bit DEDUP = 1'b1;
`else
    localparam bit DEDUP = 1'b0;
`endif

    localparam logic [IDX_W-1:0] DEPTH_I = IDX_W'(DEPTH);

    typedef enum logic [1:0] {IDLE, SCAN, APPEND, RESP} state_t;

    state_t state, state_n;

    logic [COORD_W-1:0] mem_x [DEPTH];
    logic [COORD_W-1:0] mem_y [DEPTH];

    logic [COORD_W-1:0] checkx, checky;
    logic [IDX_W-1:0]   search_index;
    logic [IDX_W-1:0]   scan_last;
    logic               op_ins;
    logic               last_grant;

    logic               grant_lk, grant_ins;
    logic               hit, last_cmp;
    logic               write_en;
    logic               load_rsp;
    logic               rsp_op_n, rsp_found_n, rsp_err_n;
    logic [IDX_W-1:0]   rsp_index_n;

    // Round-robin only matters when both requesters are valid; last_grant=1 means insert.
    always_comb begin
        grant_lk  = 1'b0;
        grant_ins = 1'b0;
        if (state == IDLE && !clear) begin
            if (bus.lk_valid && bus.ins_valid) begin
                grant_lk  = last_grant;
                grant_ins = !last_grant;
            end else begin
                grant_lk  = bus.lk_valid;
                grant_ins = bus.ins_valid;
            end
        end
    end

    assign bus.lk_ready  = grant_lk;
    assign bus.ins_ready = grant_ins;
    assign bus.rsp_valid = (state == RESP);

    assign hit      = (mem_x[search_index] == checkx) && (mem_y[search_index] == checky);
    assign last_cmp = (search_index == scan_last);
    assign full     = (count == DEPTH_I);
    assign busy     = (state != IDLE);

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n     = state;
        write_en    = 1'b0;
        load_rsp    = 1'b0;
        rsp_op_n    = op_ins;
        rsp_found_n = 1'b0;
        rsp_err_n   = 1'b0;
        rsp_index_n = '0;
        case (state)
            IDLE: begin
                rsp_op_n = 1'b0;
                if (grant_lk) begin
                    if (count == '0) begin
                        state_n  = RESP;
                        load_rsp = 1'b1;
                    end else begin
                        state_n = SCAN;
                    end
                end else if (grant_ins) begin
                    state_n = (DEDUP && count != '0) ? SCAN : APPEND;
                end
            end
            SCAN: begin
                if (hit) begin
                    state_n     = RESP;
                    load_rsp    = 1'b1;
                    rsp_found_n = 1'b1;
                    rsp_index_n = search_index;
                end else if (last_cmp) begin
                    if (op_ins) begin
                        state_n = APPEND;
                    end else begin
                        state_n  = RESP;
                        load_rsp = 1'b1;
                    end
                end
            end
            APPEND: begin
                state_n  = RESP;
                load_rsp = 1'b1;
                if (full) begin
                    rsp_err_n = 1'b1;
                end else begin
                    write_en    = 1'b1;
                    rsp_index_n = count;
                end
            end
            RESP: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            count         <= '0;
            last_grant    <= 1'b1;
            checkx        <= '0;
            checky        <= '0;
            search_index  <= '0;
            scan_last     <= '0;
            op_ins        <= 1'b0;
            bus.rsp_op    <= 1'b0;
            bus.rsp_found <= 1'b0;
            bus.rsp_index <= '0;
            bus.rsp_err   <= 1'b0;
        end else begin
            if (state == IDLE && clear) begin
                count <= '0;
            end
            if (grant_lk || grant_ins) begin
                checkx       <= grant_lk ? bus.lk_x : bus.ins_x;
                checky       <= grant_lk ? bus.lk_y : bus.ins_y;
                op_ins       <= grant_ins;
                last_grant   <= grant_ins;
                search_index <= '0;
                // Scan bound frozen at acceptance; only meaningful when count is non-zero.
                scan_last    <= count - IDX_W'(1);
            end
            if (state == SCAN && !hit && !last_cmp) begin
                search_index <= search_index + IDX_W'(1);
            end
            if (write_en) begin
                count <= count + IDX_W'(1);
            end
            if (load_rsp) begin
                bus.rsp_op    <= rsp_op_n;
                bus.rsp_found <= rsp_found_n;
                bus.rsp_index <= rsp_index_n;
                bus.rsp_err   <= rsp_err_n;
            end
        end
    end

    // Storage is deliberately unreset; only entries below count are ever compared.
    always_ff @(posedge Clk) begin
        if (write_en) begin
            mem_x[count] <= checkx;
            mem_y[count] <= checky;
        end
    end

endmodule

// File: tb/tb_closed_list_ctrl.sv
// tb/tb_closed_list_ctrl.sv - randomized scoreboard bench for closed_list_ctrl
module tb_closed_list_ctrl;

    localparam int DEPTH = 400;

    logic       Clk = 1'b0;
    logic       Reset = 1'b1;
    logic       clear = 1'b0;
    logic [8:0] count;
    logic       full;
    logic       busy;

    closed_list_ctrl_if #(.COORD_W(8), .IDX_W(9)) bus ();

    closed_list_ctrl #(.DEPTH(DEPTH), .COORD_W(8), .IDX_W(9)) dut (
        .Clk   (Clk),
        .Reset (Reset),
        .clear (clear),
        .bus   (bus),
        .count (count),
        .full  (full),
        .busy  (busy)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        int op;
        int found;
        int idx;
        int err;
        int due;
    } exp_t;

    exp_t sb[$];
    exp_t e_mon;
    int   grant_log[$];
    int   ref_x[DEPTH];
    int   ref_y[DEPTH];
    int   ref_count = 0;
    int   cyc = 0;
    int   checks = 0;
    int   fails = 0;

    always @(posedge Clk) cyc++;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int find(input int x, input int y);
        for (int i = 0; i < ref_count; i++)
            if (ref_x[i] == x && ref_y[i] == y) return i;
        return -1;
    endfunction

    task automatic model_accept(input int op, input int x, input int y);
        exp_t e;
        int   k;
        bit   do_append;
        k = find(x, y);
        e.op = op; e.found = 0; e.idx = 0; e.err = 0;
        do_append = 1'b0;
        if (op == 0) begin
            if (k >= 0) begin e.found = 1; e.idx = k; e.due = cyc + k + 2; end
            else e.due = cyc + ((ref_count == 0) ? 1 : ref_count + 1);
        end else begin
`ifdef CLOSED_DEDUP_EN
            if (k >= 0) begin e.found = 1; e.idx = k; e.due = cyc + k + 2; end
            else begin
                e.due = cyc + ((ref_count == 0) ? 2 : ref_count + 2);
                do_append = 1'b1;
            end
`else
            e.due = cyc + 2;
            do_append = 1'b1;
`endif
            if (do_append) begin
                if (ref_count == DEPTH) e.err = 1;
                else begin
                    e.idx = ref_count;
                    ref_x[ref_count] = x;
                    ref_y[ref_count] = y;
                    ref_count++;
                end
            end
        end
        sb.push_back(e);
        grant_log.push_back(op);
    endtask

    always @(negedge Clk) begin
        if (Reset) begin
            sb.delete();
            ref_count = 0;
        end else begin
            if (bus.rsp_valid) begin
                if (sb.size() == 0) chk("unexpected_rsp", 1, 0);
                else begin
                    e_mon = sb.pop_front();
                    chk("rsp_op", int'(bus.rsp_op), e_mon.op);
                    chk("rsp_found", int'(bus.rsp_found), e_mon.found);
                    chk("rsp_index", int'(bus.rsp_index), e_mon.idx);
                    chk("rsp_err", int'(bus.rsp_err), e_mon.err);
                    chk("rsp_cycle", cyc, e_mon.due);
                end
            end
            if (clear && !busy) ref_count = 0;
            if (bus.lk_valid && bus.lk_ready && bus.ins_valid && bus.ins_ready)
                chk("dual_grant", 1, 0);
            else if (bus.lk_valid && bus.lk_ready)
                model_accept(0, int'(bus.lk_x), int'(bus.lk_y));
            else if (bus.ins_valid && bus.ins_ready)
                model_accept(1, int'(bus.ins_x), int'(bus.ins_y));
        end
    end

    task automatic wait_idle();
        int n;
        n = 0;
        @(negedge Clk);
        while (busy && n < 3000) begin
            @(negedge Clk);
            n++;
        end
        if (busy) chk("idle_timeout", 1, 0);
    endtask

    task automatic serve(input bit l, input bit i, input int lx, input int ly,
                         input int ix, input int iy);
        bit lp, ip;
        int n;
        lp = l; ip = i; n = 0;
        @(posedge Clk); #1;
        bus.lk_x = 8'(lx); bus.lk_y = 8'(ly);
        bus.ins_x = 8'(ix); bus.ins_y = 8'(iy);
        bus.lk_valid = lp; bus.ins_valid = ip;
        while ((lp || ip) && n < 3000) begin
            @(negedge Clk);
            if (bus.lk_ready) lp = 1'b0;
            if (bus.ins_ready) ip = 1'b0;
            @(posedge Clk); #1;
            bus.lk_valid = lp; bus.ins_valid = ip;
            n++;
        end
        if (lp || ip) begin
            chk("accept_timeout", 1, 0);
            bus.lk_valid = 1'b0; bus.ins_valid = 1'b0;
        end
        wait_idle();
    endtask

    task automatic check_count();
        chk("count", int'(count), ref_count);
        chk("full", int'(full), int'(ref_count == DEPTH));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, r, k;
        bus.lk_valid = 0; bus.ins_valid = 0;
        bus.lk_x = 0; bus.lk_y = 0; bus.ins_x = 0; bus.ins_y = 0;
        repeat (3) @(posedge Clk);
        #1 Reset = 1'b0;
        @(negedge Clk);
        chk("rst_count", int'(count), 0);
        chk("rst_full", int'(full), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_rsp_valid", int'(bus.rsp_valid), 0);
        chk("rst_rsp_index", int'(bus.rsp_index), 0);
        chk("rst_rsp_flags", int'({bus.rsp_op, bus.rsp_found, bus.rsp_err}), 0);

        // Directed small list
        serve(0, 1, 0, 0, 3, 4);
        serve(0, 1, 0, 0, 5, 6);
        serve(0, 1, 0, 0, 7, 8);
        chk("count_after_3", int'(count), 3);
        serve(1, 0, 5, 6, 0, 0);
        serve(1, 0, 9, 9, 0, 0);
        serve(0, 1, 0, 0, 3, 4);
        serve(0, 1, 0, 0, 1, 2);
        serve(0, 1, 0, 0, 2, 1);
        check_count();

        // Clear wins over a pending lookup
        @(posedge Clk); #1;
        clear = 1'b1; bus.lk_x = 5; bus.lk_y = 6; bus.lk_valid = 1'b1;
        @(negedge Clk);
        chk("clear_no_grant", int'(bus.lk_ready), 0);
        @(posedge Clk); #1;
        clear = 1'b0; bus.lk_valid = 1'b0;
        @(negedge Clk);
        chk("count_cleared", int'(count), 0);
        serve(1, 0, 5, 6, 0, 0);

        // Fill to capacity with unique coordinates
        for (int i = ref_count; i < DEPTH; i++) serve(0, 1, 0, 0, i & 255, 200 + (i >> 8));
        check_count();
        serve(0, 1, 0, 0, 1, 1);
        chk("full_count", int'(count), DEPTH);
        chk("full_flag", int'(full), 1);
        serve(1, 0, 399 & 255, 201, 0, 0);
        for (int j = 0; j < 4; j++) begin
            k = $urandom_range(0, DEPTH - 1);
            serve(1, 0, k & 255, 200 + (k >> 8), 0, 0);
        end

        // Reset in the middle of a scan
        @(posedge Clk); #1;
        bus.lk_x = 250; bus.lk_y = 250; bus.lk_valid = 1'b1;
        n = 0;
        @(negedge Clk);
        while (!bus.lk_ready && n < 100) begin @(negedge Clk); n++; end
        @(posedge Clk); #1;
        bus.lk_valid = 1'b0;
        repeat (10) @(posedge Clk);
        #1 Reset = 1'b1;
        @(negedge Clk);
        chk("midscan_rsp_valid", int'(bus.rsp_valid), 0);
        chk("midscan_busy", int'(busy), 0);
        chk("midscan_count", int'(count), 0);
        @(posedge Clk); #1 Reset = 1'b0;

        // Both requesters held high from reset
        grant_log.delete();
        bus.lk_x = 2; bus.lk_y = 2; bus.ins_x = 2; bus.ins_y = 2;
        bus.lk_valid = 1'b1; bus.ins_valid = 1'b1;
        n = 0;
        while (grant_log.size() < 4 && n < 200) begin
            @(negedge Clk); #1;
            n++;
        end
        @(posedge Clk); #1;
        bus.lk_valid = 1'b0; bus.ins_valid = 1'b0;
        chk("rr_grants", grant_log.size(), 4);
        for (int g = 0; g < 4 && g < grant_log.size(); g++)
            chk("rr_order", grant_log[g], g % 2);
        wait_idle();
        wait_idle();
        check_count();

        // Randomized mix on a small coordinate space so hits are common
        for (int t = 0; t < 80; t++) begin
            r = $urandom_range(0, 19);
            if (r == 0) begin
                @(posedge Clk); #1 clear = 1'b1;
                @(posedge Clk); #1 clear = 1'b0;
                wait_idle();
            end else begin
                serve(r < 8 || r >= 14, r >= 8, $urandom_range(0, 3), $urandom_range(0, 3),
                      $urandom_range(0, 3), $urandom_range(0, 3));
            end
            check_count();
        end

        wait_idle();
        chk("scoreboard_empty", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
